// File: rtl/fft32_pkg.sv
// fft32_pkg: shared constants, FSM state type and bit-reverse helper for the FFT output serializer
package fft32_pkg;
  localparam int N = 32;
  localparam int W = 14;
  localparam int IDX_W = 5;
  localparam int CNT_W = 16;
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] x);
    logic [IDX_W-1:0] r;
    for (int i = 0; i < IDX_W; i++) r[i] = x[IDX_W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft32_frame_bank.sv
// fft32_frame_bank: N x 2W frame store; clk/rst, we loads re_flat/im_flat whole, addr selects rd_re/rd_im asynchronously
module fft32_frame_bank
  import fft32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [N*W-1:0]   re_flat,
  input  logic [N*W-1:0]   im_flat,
  input  logic [IDX_W-1:0] addr,
  output logic [W-1:0]     rd_re,
  output logic [W-1:0]     rd_im
);
  logic [N*W-1:0] re_q, im_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      re_q <= '0;
      im_q <= '0;
    end else if (we) begin
      re_q <= re_flat;
      im_q <= im_flat;
    end
  assign rd_re = re_q[addr*W +: W];
  assign rd_im = im_q[addr*W +: W];
endmodule

// File: rtl/fft32_out_serializer.sv
// fft32_out_serializer: captures a 32-bin complex frame on frame_valid, streams one bin per out_valid/out_ready beat with out_idx/out_last, counts frame_cnt/drop_cnt; FFT32_OUT_BITREV_EN reads the bank in bit-reversed order
module fft32_out_serializer
  import fft32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_valid,
  input  logic [N*W-1:0]   re_flat,
  input  logic [N*W-1:0]   im_flat,
  output logic             frame_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_re,
  output logic [W-1:0]     out_im,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       drop_cnt
);
  state_t           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d, a;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             xfer, load;
  logic [W-1:0]     rd_re, rd_im;
  assign out_valid   = state_q == STREAM;
  assign xfer        = out_valid && out_ready;
  assign out_last    = out_valid && k_q == IDX_W'(N-1);
  assign frame_ready = !out_valid || (out_last && out_ready);
  assign load        = frame_valid && frame_ready;
`ifdef FFT32_OUT_BITREV_EN
  assign a = bitrev(k_q);
`else
  assign a = k_q;
`endif
  always_comb begin
    state_d     = load ? STREAM : (xfer && out_last) ? IDLE : state_q;
    k_d         = load ? '0 : xfer ? k_q + 1'b1 : k_q;
    frame_cnt_d = frame_cnt_q + CNT_W'(xfer && out_last);
    drop_cnt_d  = drop_cnt_q + 8'(frame_valid && !frame_ready && drop_cnt_q != 8'hff);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  fft32_frame_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (load),
    .re_flat (re_flat),
    .im_flat (im_flat),
    .addr    (a),
    .rd_re   (rd_re),
    .rd_im   (rd_im)
  );
  assign out_re    = out_valid ? rd_re : '0;
  assign out_im    = out_valid ? rd_im : '0;
  assign out_idx   = out_valid ? a : '0;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_fft32_out_serializer.sv
// tb_fft32_out_serializer: table-driven and scoreboard checks of the FFT output serializer
module tb_fft32_out_serializer;
  import fft32_pkg::*;
  logic clk = 0, rst = 1, frame_valid = 0, out_ready;
  logic [N*W-1:0] re_flat = '0, im_flat = '0;
  logic frame_ready, out_valid, out_last;
  logic [W-1:0] out_re, out_im;
  logic [IDX_W-1:0] out_idx;
  logic [CNT_W-1:0] frame_cnt;
  logic [7:0] drop_cnt;
  fft32_out_serializer dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .re_flat(re_flat), .im_flat(im_flat),
    .frame_ready(frame_ready), .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re),
    .out_im(out_im), .out_idx(out_idx), .out_last(out_last), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {logic [IDX_W-1:0] idx; logic [W-1:0] re; logic [W-1:0] im; logic last;} beat_t;
  typedef struct {int mode; logic [3:0] rpat; int exp_fc; int exp_cyc;} vec_t;
  beat_t sb[$];
  beat_t e_m;
  vec_t vt[4];
  int total = 0, bad = 0;
  logic [W-1:0] re_f[N], im_f[N];
  logic [3:0] rpat = 4'hf;
  logic [1:0] ph = 0;
  bit prev_stall = 0;
  logic [W-1:0] prev_re;
  logic [IDX_W-1:0] prev_idx;
  always @(posedge clk) begin
    #1 out_ready = rpat[ph];
    ph = ph + 2'd1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [IDX_W-1:0] a_of(input int k);
    logic [IDX_W-1:0] x;
    x = IDX_W'(k);
`ifdef FFT32_OUT_BITREV_EN
    return {x[0], x[1], x[2], x[3], x[4]};
`else
    return x;
`endif
  endfunction
  task automatic gen(input int mode);
    for (int k = 0; k < N; k++) begin
      case (mode)
        0: begin re_f[k] = W'(k); im_f[k] = W'(-k); end
        1: begin re_f[k] = W'(k * 517 - 8000); im_f[k] = W'(3000 - k * 211); end
        2: begin re_f[k] = W'(k + 200); im_f[k] = W'(k - 300); end
        default: begin re_f[k] = W'($urandom); im_f[k] = W'($urandom); end
      endcase
    end
    if (mode == 1) begin
      re_f[0] = 14'h2000;
      im_f[0] = 14'h1fff;
      re_f[N-1] = 14'h1fff;
      im_f[N-1] = 14'h2000;
    end
    for (int k = 0; k < N; k++) begin
      re_flat[k*W +: W] = re_f[k];
      im_flat[k*W +: W] = im_f[k];
    end
  endtask
  task automatic push_frame();
    for (int k = 0; k < N; k++) begin
      logic [IDX_W-1:0] a;
      a = a_of(k);
      sb.push_back('{a, re_f[a], im_f[a], (k == N-1)});
    end
  endtask
  task automatic strobe();
    @(posedge clk);
    #1 frame_valid = 1;
    push_frame();
    @(posedge clk);
    #1 frame_valid = 0;
  endtask
  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'({sb.size() != 0, out_valid}), 32'd0);
  endtask
  task automatic wait_idx(input logic [IDX_W-1:0] t);
    int n = 0;
    while (!(out_valid && out_idx == t) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx", 32'(out_idx), 32'(t));
  endtask
  always @(negedge clk) begin
    if (!rst && prev_stall) begin
      chk("stall_re", 32'(out_re), 32'(prev_re));
      chk("stall_idx", 32'(out_idx), 32'(prev_idx));
    end
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_beat idx=%0d expected no beat", out_idx);
      end else begin
        e_m = sb.pop_front();
        chk("beat_idx", 32'(out_idx), 32'(e_m.idx));
        chk("beat_re", 32'(out_re), 32'(e_m.re));
        chk("beat_im", 32'(out_im), 32'(e_m.im));
        chk("beat_last", 32'(out_last), 32'(e_m.last));
      end
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev_re = out_re;
    prev_idx = out_idx;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n;
    vt[0] = '{0, 4'hf, 1, 32};
    vt[1] = '{0, 4'b1001, 2, 0};
    vt[2] = '{1, 4'hf, 3, 32};
    vt[3] = '{3, 4'b0101, 4, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(frame_ready), 32'd1);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_re", 32'(out_re), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_dcnt", 32'(drop_cnt), 32'd0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rpat = vt[i].rpat;
      gen(vt[i].mode);
      strobe();
      @(negedge clk);
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_idx", 32'(out_idx), 32'd0);
      wait_idle(400, n);
      if (vt[i].exp_cyc != 0) chk("cycles", 32'(n), 32'(vt[i].exp_cyc));
      chk("vec_fcnt", 32'(frame_cnt), 32'(vt[i].exp_fc));
      chk("vec_dcnt", 32'(drop_cnt), 32'd0);
    end
    rpat = 4'hf;
    gen(2);
    strobe();
    wait_idx(a_of(10));
    chk("busy_ready", 32'(frame_ready), 32'd0);
    gen(3);
    frame_valid = 1;
    @(posedge clk);
    #1 frame_valid = 0;
    @(negedge clk);
    chk("drop_cnt1", 32'(drop_cnt), 32'd1);
    chk("after_drop_idx", 32'(out_idx), 32'(a_of(11)));
    wait_idx(a_of(31));
    chk("last_ready", 32'(frame_ready), 32'd1);
    chk("last_flag", 32'(out_last), 32'd1);
    gen(1);
    frame_valid = 1;
    push_frame();
    @(posedge clk);
    #1 frame_valid = 0;
    @(negedge clk);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_idx", 32'(out_idx), 32'd0);
    chk("b2b_fcnt", 32'(frame_cnt), 32'd5);
    wait_idle(400, n);
    chk("b2b_fcnt_end", 32'(frame_cnt), 32'd6);
    @(negedge clk);
    rpat = 4'h0;
    gen(2);
    push_frame();
    @(posedge clk);
    #1 frame_valid = 1;
    repeat (300) @(posedge clk);
    #1 frame_valid = 0;
    @(negedge clk);
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    rpat = 4'hf;
    wait_idle(400, n);
    chk("sat_fcnt", 32'(frame_cnt), 32'd7);
    gen(0);
    strobe();
    wait_idx(a_of(5));
    #2 rst = 1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_idx", 32'(out_idx), 32'd0);
    chk("arst_re", 32'(out_re), 32'd0);
    chk("arst_im", 32'(out_im), 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    chk("arst_ready", 32'(frame_ready), 32'd1);
    chk("arst_fcnt", 32'(frame_cnt), 32'd0);
    chk("arst_dcnt", 32'(drop_cnt), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    gen(2);
    strobe();
    @(negedge clk);
    chk("post_valid", 32'(out_valid), 32'd1);
    chk("post_idx", 32'(out_idx), 32'd0);
    wait_idle(400, n);
    chk("post_fcnt", 32'(frame_cnt), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
